// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for a three-address ALU machine on an 8-word RAM:
// fetch, decode, read two operands, execute, write back, with halt and single-step.
module cpu_sequencer #(
    parameter int HALT_BIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    output logic        busy,
    output logic        done,
    output logic        halted,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [2:0]  ram_adr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic [31:0] pc_val,
    output logic        pc_inc,
    output logic        pc_reset,
    output logic        alu_s1,
    output logic        alu_s0,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_out,
    output logic [31:0] ir
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD_IR = 3'd2,
        S_READ_A  = 3'd3,
        S_READ_B  = 3'd4,
        S_EXEC    = 3'd5,
        S_WRITE   = 3'd6,
        S_HALT    = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [2:0]  adr_q, adr_d;
    logic        wr_q, wr_d;
    logic        inc_q, inc_d;
    logic        s1_q, s1_d;
    logic        s0_q, s0_d;
    logic        done_q, done_d;
    logic        halted_q, halted_d;
    logic        step_q, step_d;
    logic        stepped_q, stepped_d;
    logic        busy_q, busy_d;
    logic        unused_pc_hi;

    assign unused_pc_hi = ^pc_val[31:3];

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        x_d       = x_q;
        y_d       = y_q;
        adr_d     = adr_q;
        wr_d      = 1'b0;
        inc_d     = 1'b0;
        s1_d      = s1_q;
        s0_d      = s0_q;
        done_d    = 1'b0;
        halted_d  = halted_q;
        step_d    = step_q;
        stepped_d = stepped_q;
        busy_d    = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    halted_d  = 1'b0;
                    step_d    = step;
                    stepped_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD_IR;
            S_LOAD_IR: begin
                ir_d = ram_dout;
                if (ram_dout[HALT_BIT]) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ_A;
                    adr_d   = ram_dout[6:4];
                end
            end
            // Operand addresses lead the data by one cycle (synchronous RAM).
            S_READ_A: begin
                adr_d   = ir_q[2:0];
                state_d = S_READ_B;
            end
            S_READ_B: begin
                x_d     = ram_dout;
                s1_d    = ir_q[13];
                s0_d    = ir_q[12];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                y_d     = ram_dout;
                adr_d   = ir_q[10:8];
                wr_d    = 1'b1;
                inc_d   = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                s1_d = 1'b0;
                s0_d = 1'b0;
                if (step_q) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    stepped_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            adr_q     <= '0;
            wr_q      <= 1'b0;
            inc_q     <= 1'b0;
            s1_q      <= 1'b0;
            s0_q      <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            step_q    <= 1'b0;
            stepped_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            adr_q     <= adr_d;
            wr_q      <= wr_d;
            inc_q     <= inc_d;
            s1_q      <= s1_d;
            s0_q      <= s0_d;
            done_q    <= done_d;
            halted_q  <= halted_d;
            step_q    <= step_d;
            stepped_q <= stepped_d;
            busy_q    <= busy_d;
        end
    end

    // A resumed run (after halt or a single step) keeps the current PC.
    assign pc_reset = reset & (state_q == S_IDLE) & start
                    & ~halted_q & ~stepped_q;

    assign ram_adr = (state_q == S_FETCH) ? pc_val[2:0] : adr_q;
    assign ram_din = (state_q == S_WRITE) ? alu_out : '0;
    assign ram_wr  = wr_q;
    assign ram_en  = busy_q;
    assign busy    = busy_q;
    assign pc_inc  = inc_q;
    assign done    = done_q;
    assign halted  = halted_q;
    assign alu_s1  = s1_q;
    assign alu_s0  = s0_q;
    assign alu_x   = x_q;
    assign alu_y   = y_q;
    assign ir      = ir_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: RAM, PC and ALU models around the DUT,
// with an instruction-level reference model predicting writes and done pulses.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, step;
    logic        busy, done, halted, ram_en, ram_wr;
    logic [2:0]  ram_adr;
    logic [31:0] ram_din, ram_dout, alu_x, alu_y, alu_out, ir;
    logic        pc_inc, pc_reset, alu_s1, alu_s0;
    logic [31:0] pc = 32'hDEAD_BEEF;
    logic        load;

    logic [31:0] mem [8];
    logic [31:0] img [8];
    logic [31:0] ref_mem [8];
    logic [31:0] ref_pc = '0;
    bit          ref_halted, ref_stepped;

    typedef struct {
        bit          is_done;
        logic [2:0]  adr;
        logic [31:0] data;
        int          cyc;
    } ev_t;
    ev_t exp_q [$];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int busy_prev = 0;
    int inc_cnt = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.HALT_BIT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .step(step),
        .busy(busy), .done(done), .halted(halted),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_adr(ram_adr),
        .ram_din(ram_din), .ram_dout(ram_dout), .pc_val(pc),
        .pc_inc(pc_inc), .pc_reset(pc_reset),
        .alu_s1(alu_s1), .alu_s0(alu_s0),
        .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out), .ir(ir)
    );

    function automatic logic [31:0] alu_f(input logic [1:0] s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_f({alu_s1, alu_s0}, alu_x, alu_y);

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) mem[i] <= img[i];
        end else if (ram_en) begin
            if (ram_wr) mem[ram_adr] <= ram_din;
            else ram_dout <= mem[ram_adr];
        end
    end

    always @(posedge clk) begin
        if (pc_reset) pc <= '0;
        else if (pc_inc) pc <= pc + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cyc = 0;
                busy_prev = 0;
                continue;
            end
            cyc = (busy && busy_prev == 0) ? 1 : cyc + 1;
            busy_prev = busy ? 1 : 0;
            if (pc_inc) inc_cnt++;
            chk("ram_en vs busy", ram_en, busy);
            chk("pc_inc vs ram_wr", pc_inc, ram_wr);
            chk("pc_reset while busy", pc_reset & busy, 0);
            if (ram_wr || done) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL scoreboard: unexpected done=%0d adr=%0d data=%h cyc=%0d",
                             done, ram_adr, ram_din, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done != done || e.cyc != cyc ||
                        (!e.is_done && (e.adr !== ram_adr || e.data !== ram_din))) begin
                        nerr++;
                        $display("FAIL scoreboard: got done=%0d adr=%0d data=%h cyc=%0d, expected done=%0d adr=%0d data=%h cyc=%0d",
                                 done, ram_adr, ram_din, cyc,
                                 e.is_done, e.adr, e.data, e.cyc);
                    end
                end
            end
        end
    endtask

    // Instruction-level model: executes whole instructions on ref_mem.
    task automatic run_model(input bit stp, input int maxi, output int nwr);
        logic [31:0] w, res;
        nwr = 0;
        if (!ref_halted && !ref_stepped) ref_pc = '0;
        ref_halted = 0;
        ref_stepped = 0;
        for (int k = 0; k < maxi; k++) begin
            w = ref_mem[ref_pc[2:0]];
            if (w[15]) begin
                exp_q.push_back('{1'b1, 3'd0, 32'd0, 6 * k + 3});
                ref_halted = 1;
                return;
            end
            res = alu_f(w[13:12], ref_mem[w[6:4]], ref_mem[w[2:0]]);
            ref_mem[w[10:8]] = res;
            exp_q.push_back('{1'b0, w[10:8], res, 6 * k + 6});
            nwr++;
            ref_pc = ref_pc + 32'd1;
            if (stp) begin
                exp_q.push_back('{1'b1, 3'd0, 32'd0, 7});
                ref_stepped = 1;
                return;
            end
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) ref_mem[i] = img[i];
        @(negedge clk);
        #2 load = 1'b1;
        @(negedge clk);
        #2 load = 1'b0;
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, " busy"}, busy, 0);
        chk({t, " done"}, done, 0);
        chk({t, " halted"}, halted, 0);
        chk({t, " ram_en"}, ram_en, 0);
        chk({t, " ram_wr"}, ram_wr, 0);
        chk({t, " ram_adr"}, ram_adr, 0);
        chk({t, " pc_inc"}, pc_inc, 0);
        chk({t, " pc_reset"}, pc_reset, 0);
        chk({t, " alu_s1"}, alu_s1, 0);
        chk({t, " alu_s0"}, alu_s0, 0);
        chk({t, " ir"}, ir, 0);
        chk({t, " alu_x"}, alu_x, 0);
        chk({t, " alu_y"}, alu_y, 0);
    endtask

    task automatic clear_model();
        ref_halted = 0;
        ref_stepped = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        clear_model();
    endtask

    task automatic wait_idle(input string t);
        int n = 0;
        do begin
            @(negedge clk);
            #3 n++;
        end while ((exp_q.size() != 0 || busy) && n < 300);
        chk({t, " completion"}, (exp_q.size() == 0 && !busy), 1);
        for (int i = 0; i < 8; i++) chk({t, " ram word"}, mem[i], ref_mem[i]);
        chk({t, " halted"}, halted, ref_halted);
    endtask

    task automatic run(input string t, input bit stp, input int maxi);
        bit exp_pr;
        int nwr, inc0;
        exp_pr = !ref_halted && !ref_stepped;
        run_model(stp, maxi, nwr);
        inc0 = inc_cnt;
        @(negedge clk);
        #2 start = 1'b1;
        step = stp;
        #1 chk({t, " pc_reset at accept"}, pc_reset, exp_pr);
        @(negedge clk);
        #2 start = 1'($urandom);
        step = 1'($urandom);
        @(negedge clk);
        #2 start = 1'b0;
        step = 1'($urandom);
        wait_idle(t);
        chk({t, " pc_inc count"}, inc_cnt - inc0, nwr);
    endtask

    task automatic prog_basic();
        for (int i = 0; i < 8; i++) img[i] = '0;
        img[0] = 32'h0000_3234;
        img[1] = 32'h0000_8000;
        img[3] = 32'd5;
        img[4] = 32'd7;
    endtask

    initial begin
        int n1, n2, k;
        logic [2:0] h;
        logic [31:0] w;
        start = 1'b0;
        step = 1'b0;
        load = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        #2 reset = 1'b1;
        clear_model();

        prog_basic();
        load_prog();
        run("basic", 1'b0, 16);
        chk("basic ram2", mem[2], 32'h2);
        chk("basic busy", busy, 0);

        do_reset();
        load_prog();
        run("step1", 1'b1, 16);
        run("step2", 1'b0, 16);

        do_reset();
        for (int i = 0; i < 8; i++) img[i] = '0;
        img[0] = 32'h0000_0334;
        img[1] = 32'h0000_8000;
        img[3] = 32'd5;
        img[4] = 32'd7;
        load_prog();
        run("aliased", 1'b0, 16);
        chk("aliased ram3", mem[3], 32'd12);
        chk("aliased alu_x old", alu_x, 32'd5);
        chk("aliased alu_y", alu_y, 32'd7);

        do_reset();
        prog_basic();
        load_prog();
        run_model(1'b0, 16, n1);
        run_model(1'b0, 16, n2);
        @(negedge clk);
        #2 start = 1'b1;
        step = 1'b0;
        #1 chk("held pc_reset first", pc_reset, 1);
        k = 0;
        do begin
            @(negedge clk);
            #3 k++;
        end while (!done && k < 100);
        chk("held first done", done, 1);
        k = 0;
        do begin
            @(negedge clk);
            #3 k++;
            if (!busy) chk("held pc_reset on restart", pc_reset, 0);
        end while (!done && k < 50);
        chk("held restart gap", k, 4);
        start = 1'b0;
        wait_idle("held");

        do_reset();
        for (int i = 0; i < 8; i++)
            img[i] = 32'h2000 | (i << 8) | (i << 4) | i;
        load_prog();
        run_model(1'b0, 8, n1);
        @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk);
        #2 start = 1'b0;
        k = 0;
        while (cyc != 49 && k < 200) begin
            @(negedge clk);
            #1 k++;
        end
        chk("wrap fetch cycle", cyc, 49);
        chk("wrap ram_adr", ram_adr, 0);
        chk("wrap writes drained", exp_q.size(), 0);
        while (cyc != 51 && k < 200) begin
            @(negedge clk);
            #1 k++;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("reset in READ_B");
        #1 reset = 1'b1;
        clear_model();

        for (int i = 0; i < 8; i++) img[i] = '0;
        img[0] = 32'h0000_0534;
        img[1] = 32'h0000_8000;
        img[3] = 32'd5;
        img[4] = 32'd7;
        img[5] = 32'h55;
        load_prog();
        @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk);
        #2 start = 1'b0;
        k = 0;
        while (cyc != 5 && k < 100) begin
            @(negedge clk);
            #1 k++;
        end
        @(posedge clk);
        #1 chk("write strobe before reset", ram_wr, 1);
        #1 reset = 1'b0;
        #1 check_reset_vals("reset in WRITE");
        #1 reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        chk("no write after reset", mem[5], 32'h55);

        for (int it = 0; it < 30; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0) begin
                h = 3'($urandom_range(0, 7));
                for (int i = 0; i < 8; i++) begin
                    w = $urandom;
                    if (i == int'(h)) begin
                        w[15] = 1'b1;
                    end else begin
                        w[15] = 1'b0;
                        if (w[10:8] == h) w[10:8] = h + 3'd1;
                    end
                    img[i] = w;
                end
                load_prog();
            end
            if ($urandom_range(0, 9) == 0) do_reset();
            run("random", 1'($urandom_range(0, 1)), 16);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
